// File: rtl/nmcu_pkg.sv
// Shared types for the NMCU memory subsystem.
package nmcu_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StRelease
   } arb_state_t;

endpackage

// File: rtl/nmcu_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping at NUM_REQ.
module nmcu_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic               valid_o,
   output logic [IW-1:0]      idx_o
);

   always_comb begin
      int unsigned j;
      logic [IW-1:0] jidx;
      valid_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      jidx    = '0;
      // Scan farthest-first so the closest hit to ptr_i is the last assignment.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = 32'(ptr_i) + 32'(i);
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jidx = IW'(j);
         if (req_i[jidx]) begin
            valid_o = 1'b1;
            idx_o   = jidx;
         end
      end
   end

endmodule

// File: rtl/nmcu_mem_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters single-word access to one memory port,
// with a watchdog that aborts transactions the memory never acknowledges.
module nmcu_mem_arbiter
   import nmcu_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned DATABUS_WIDTH  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned IW             = $clog2(NUM_REQ)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_REQ-1:0]       req_sel_i,
   input  logic [NUM_REQ-1:0]       req_w_i,
   input  logic [ADDR_WIDTH-1:0]    req_addr_i  [NUM_REQ],
   input  logic [DATABUS_WIDTH-1:0] req_wdata_i [NUM_REQ],
   output logic [NUM_REQ-1:0]       req_ready_o,
   output logic [NUM_REQ-1:0]       req_err_o,
   output logic [DATABUS_WIDTH-1:0] req_rdata_o,
   output logic                     mem_sel_o,
   output logic                     mem_w_o,
   output logic [ADDR_WIDTH-1:0]    mem_addr_o,
   output logic [DATABUS_WIDTH-1:0] mem_wdata_o,
   input  logic                     mem_ready_i,
   input  logic [DATABUS_WIDTH-1:0] mem_rdata_i,
   output logic [IW-1:0]            grant_id_o,
   output logic                     busy_o,
   output logic                     err_sticky_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

   arb_state_t               state_q, state_d;
   logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [IW-1:0]            grant_q, grant_d;
   logic                     mem_sel_q, mem_sel_d;
   logic                     mem_w_q, mem_w_d;
   logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
   logic [DATABUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [NUM_REQ-1:0]       req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]       req_err_q, req_err_d;
   logic [DATABUS_WIDTH-1:0] req_rdata_q, req_rdata_d;
   logic                     err_sticky_q, err_sticky_d;

   logic                     pick_valid;
   logic [IW-1:0]            pick_idx;

   nmcu_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_pick (
      .req_i   (req_sel_i),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      mem_sel_d    = mem_sel_q;
      mem_w_d      = mem_w_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      req_ready_d  = '0;
      req_err_d    = '0;
      req_rdata_d  = req_rdata_q;
      err_sticky_d = err_sticky_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d     = StAccess;
               grant_d     = pick_idx;
               mem_sel_d   = 1'b1;
               mem_w_d     = req_w_i[pick_idx];
               mem_addr_d  = req_addr_i[pick_idx];
               mem_wdata_d = req_wdata_i[pick_idx];
               cnt_d       = '0;
            end
         end
         StAccess: begin
            if (mem_ready_i) begin
               state_d              = StRelease;
               mem_sel_d            = 1'b0;
               mem_w_d              = 1'b0;
               req_ready_d[grant_q] = 1'b1;
               req_rdata_d          = mem_rdata_i;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d            = StRelease;
               mem_sel_d          = 1'b0;
               mem_w_d            = 1'b0;
               req_err_d[grant_q] = 1'b1;
               req_rdata_d        = '0;
               err_sticky_d       = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRelease: begin
            state_d  = StIdle;
            rr_ptr_d = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         cnt_q        <= '0;
         grant_q      <= '0;
         mem_sel_q    <= 1'b0;
         mem_w_q      <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         req_ready_q  <= '0;
         req_err_q    <= '0;
         req_rdata_q  <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         mem_sel_q    <= mem_sel_d;
         mem_w_q      <= mem_w_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         req_ready_q  <= req_ready_d;
         req_err_q    <= req_err_d;
         req_rdata_q  <= req_rdata_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign req_ready_o  = req_ready_q;
   assign req_err_o    = req_err_q;
   assign req_rdata_o  = req_rdata_q;
   assign mem_sel_o    = mem_sel_q;
   assign mem_w_o      = mem_w_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign grant_id_o   = grant_q;
   assign busy_o       = (state_q != StIdle);
   assign err_sticky_o = err_sticky_q;

endmodule
